mram_burst_ctrl: RTL

MRAM_BURST_CTRL -- requirements
Module: mram_burst_ctrl

---
 rtl/mram_pkg.sv | 26 ++
 rtl/sync_edge_det.sv | 39 +++
 rtl/mram_burst_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/mram_pkg.sv
// Shared widths, timing defaults and FSM encoding for the MRAM burst controller.
package mram_pkg;

    localparam int ADDR_W    = 20;
    localparam int DATA_W    = 16;
    localparam int CNT_W     = 4;
    localparam int T_ACC_DEF = 4;
    localparam int T_WP_DEF  = 3;

    typedef enum logic [2:0] {
        IDLE,
        RD_SETUP,
        RD_ACC,
        RD_WORD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        FINISH
    } state_t;

    // A disabled or zero-length burst still transfers exactly one word.
    function automatic logic [CNT_W-1:0] word_count(input logic en, input logic [CNT_W-1:0] len);
        return (en && len != '0) ? len : {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a rising-edge pulse for a slow level command.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic level,
    output logic pulse
);

    logic meta;
    logic sync;
    logic prev;
    logic warm1;
    logic warm2;
    logic armed;

    // Only arm after a genuine synchronized low, so a level still high across reset is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            prev  <= 1'b0;
            warm1 <= 1'b0;
            warm2 <= 1'b0;
            armed <= 1'b0;
        end else begin
            meta  <= level;
            sync  <= meta;
            prev  <= sync;
            warm1 <= 1'b1;
            warm2 <= warm1;
            if (warm2 && !sync) begin
                armed <= 1'b1;
            end
        end
    end

    assign pulse = armed & sync & ~prev;

endmodule

// File: rtl/mram_burst_ctrl.sv
// Burst read/write sequencer for an asynchronous parallel MRAM, driven by
// level commands arriving from the I2C slave clock domain.
module mram_burst_ctrl
    import mram_pkg::*;
#(
    parameter int T_ACC = T_ACC_DEF,
    parameter int T_WP  = T_WP_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              read_signal,
    input  logic              write_signal,
    input  logic              burst_en,
    input  logic [CNT_W-1:0]  burst_len_out,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    output logic [DATA_W-1:0] data_from_MRAM,
    output logic              rd_valid,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mram_addr,
    output logic [DATA_W-1:0] mram_dq_out,
    output logic              mram_dq_oe,
    input  logic [DATA_W-1:0] mram_dq_in,
    output logic              mram_ce_n,
    output logic              mram_oe_n,
    output logic              mram_we_n,
    output logic              mram_ub_n,
    output logic              mram_lb_n
);

    localparam logic [CNT_W-1:0] ACC_LOAD = CNT_W'(T_ACC - 1);
    localparam logic [CNT_W-1:0] WP_LOAD  = CNT_W'(T_WP - 1);

    logic             rd_edge;
    logic             wr_edge;
    state_t           state;
    logic [CNT_W-1:0] words_left;
    logic [CNT_W-1:0] timer;

    sync_edge_det u_rd_sync (
        .clk   (clk),
        .rst   (rst),
        .level (read_signal),
        .pulse (rd_edge)
    );

    sync_edge_det u_wr_sync (
        .clk   (clk),
        .rst   (rst),
        .level (write_signal),
        .pulse (wr_edge)
    );

    // Every output is assigned on the transition into the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            words_left     <= '0;
            timer          <= '0;
            data_from_MRAM <= '0;
            rd_valid       <= 1'b0;
            done           <= 1'b0;
            busy           <= 1'b0;
            mram_addr      <= '0;
            mram_dq_out    <= '0;
            mram_dq_oe     <= 1'b0;
            mram_ce_n      <= 1'b1;
            mram_oe_n      <= 1'b1;
            mram_we_n      <= 1'b1;
            mram_ub_n      <= 1'b1;
            mram_lb_n      <= 1'b1;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    // Write wins a same-cycle collision; the read edge is simply lost.
                    if (wr_edge) begin
                        state       <= WR_SETUP;
                        mram_addr   <= write_addr;
                        words_left  <= word_count(burst_en, burst_len_out);
                        busy        <= 1'b1;
                        mram_ce_n   <= 1'b0;
                        mram_ub_n   <= 1'b0;
                        mram_lb_n   <= 1'b0;
                        mram_dq_oe  <= 1'b1;
                        mram_dq_out <= write_data;
                    end else if (rd_edge) begin
                        state      <= RD_SETUP;
                        mram_addr  <= write_addr;
                        words_left <= word_count(burst_en, burst_len_out);
                        busy       <= 1'b1;
                        mram_ce_n  <= 1'b0;
                        mram_ub_n  <= 1'b0;
                        mram_lb_n  <= 1'b0;
                    end
                end
                RD_SETUP: begin
                    state     <= RD_ACC;
                    mram_oe_n <= 1'b0;
                    timer     <= ACC_LOAD;
                end
                RD_ACC: begin
                    if (timer == '0) begin
                        state          <= RD_WORD;
                        mram_oe_n      <= 1'b1;
                        data_from_MRAM <= mram_dq_in;
                        rd_valid       <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                RD_WORD: begin
                    if (words_left == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state     <= FINISH;
                        done      <= 1'b1;
                        mram_ce_n <= 1'b1;
                        mram_ub_n <= 1'b1;
                        mram_lb_n <= 1'b1;
                    end else begin
                        state      <= RD_SETUP;
                        words_left <= words_left - 1'b1;
                        mram_addr  <= mram_addr + 1'b1;
                    end
                end
                WR_SETUP: begin
                    state     <= WR_PULSE;
                    mram_we_n <= 1'b0;
                    timer     <= WP_LOAD;
                end
                WR_PULSE: begin
                    if (timer == '0) begin
                        state     <= WR_HOLD;
                        mram_we_n <= 1'b1;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                WR_HOLD: begin
                    // Address only moves after the hold cycle so it never changes under an active pulse.
                    if (words_left == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                        state      <= FINISH;
                        done       <= 1'b1;
                        mram_ce_n  <= 1'b1;
                        mram_ub_n  <= 1'b1;
                        mram_lb_n  <= 1'b1;
                        mram_dq_oe <= 1'b0;
                    end else begin
                        state       <= WR_SETUP;
                        words_left  <= words_left - 1'b1;
                        mram_addr   <= mram_addr + 1'b1;
                        mram_dq_out <= write_data;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    mram_dq_oe <= 1'b0;
                    mram_ce_n  <= 1'b1;
                    mram_oe_n  <= 1'b1;
                    mram_we_n  <= 1'b1;
                    mram_ub_n  <= 1'b1;
                    mram_lb_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule
